// File: rtl/datapath_pkg.sv
// datapath_pkg: shared state, ALU, shifter and writeback-source encodings for datapath_seq
package datapath_pkg;
  typedef enum logic [2:0] {IDLE, LOADA, LOADB, EXEC, WB} state_t;
  typedef enum logic [1:0] {ADD, SUB, AND, NOT} alu_op_t;
  typedef enum logic [1:0] {NONE, LSL1, LSR1, ASR1} shift_t;
  typedef enum logic [1:0] {VS_C, VS_PC, VS_IMM8, VS_MDATA} vsel_t;
endpackage

// File: rtl/regfile_param.sv
// regfile_param: NREGS x WIDTH register file, async reset, one combinational read, one sync write
module regfile_param #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_we,
  input  logic [RW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [RW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [NREGS];
  assign o_rdata = r_mem[i_raddr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: self-sequenced datapath; one op per handshake runs LOADA, LOADB, EXEC, WB
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW = 8,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [RW-1:0]    rd_a,
  input  logic [RW-1:0]    rd_b,
  input  logic [RW-1:0]    wr_num,
  input  logic             wr_en,
  input  logic [1:0]       vsel,
  input  logic [1:0]       shift,
  input  logic [1:0]       alu_op,
  input  logic             asel,
  input  logic             bsel,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [WIDTH-1:0] sximm8,
  input  logic [PCW-1:0]   pc,
  input  logic [WIDTH-1:0] mdata,
  output logic [WIDTH-1:0] C,
  output logic             N,
  output logic             V,
  output logic             Z,
  output logic             done
);
  state_t           r_state, w_next;
  logic [RW-1:0]    r_rd_a, r_rd_b, r_wr_num, w_raddr;
  logic             r_wr_en, r_asel, r_bsel, w_accept, w_v, w_we;
  vsel_t            r_vsel;
  shift_t           r_shift;
  alu_op_t          r_alu_op;
  logic [PCW-1:0]   r_pc;
  logic [WIDTH-1:0] r_sximm5, r_sximm8, r_a, r_b;
  logic [WIDTH-1:0] w_rdata, w_ain, w_bsh, w_bin, w_res, w_wdata;
  assign op_ready = r_state == IDLE;
  assign done = r_state == WB;
  assign w_accept = op_valid && op_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? LOADA : IDLE;
      LOADA:   w_next = LOADB;
      LOADB:   w_next = EXEC;
      EXEC:    w_next = WB;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
      r_wr_num <= '0;
      r_wr_en <= 1'b0;
      r_vsel <= VS_C;
      r_shift <= NONE;
      r_alu_op <= ADD;
      r_asel <= 1'b0;
      r_bsel <= 1'b0;
      r_sximm5 <= '0;
      r_sximm8 <= '0;
      r_pc <= '0;
    end else if (w_accept) begin
      r_rd_a <= rd_a;
      r_rd_b <= rd_b;
      r_wr_num <= wr_num;
      r_wr_en <= wr_en;
      r_vsel <= vsel_t'(vsel);
      r_shift <= shift_t'(shift);
      r_alu_op <= alu_op_t'(alu_op);
      r_asel <= asel;
      r_bsel <= bsel;
      r_sximm5 <= sximm5;
      r_sximm8 <= sximm8;
      r_pc <= pc;
    end
  // single read port is shared: LOADB reads B, every other state presents A
  assign w_raddr = r_state == LOADB ? r_rd_b : r_rd_a;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (r_state == LOADA) r_a <= w_rdata;
      if (r_state == LOADB) r_b <= w_rdata;
    end
  always_comb begin
    w_ain = r_asel ? '0 : r_a;
    w_bsh = r_shift == LSL1 ? {r_b[WIDTH-2:0], 1'b0} :
            r_shift == LSR1 ? {1'b0, r_b[WIDTH-1:1]} :
            r_shift == ASR1 ? {r_b[WIDTH-1], r_b[WIDTH-1:1]} : r_b;
    w_bin = r_bsel ? r_sximm5 : w_bsh;
    w_res = r_alu_op == ADD ? w_ain + w_bin :
            r_alu_op == SUB ? w_ain - w_bin :
            r_alu_op == AND ? w_ain & w_bin : ~w_bin;
    w_v = r_alu_op == ADD ? (w_ain[WIDTH-1] == w_bin[WIDTH-1]) && (w_res[WIDTH-1] != w_ain[WIDTH-1]) :
          r_alu_op == SUB ? (w_ain[WIDTH-1] != w_bin[WIDTH-1]) && (w_res[WIDTH-1] != w_ain[WIDTH-1]) : 1'b0;
    w_wdata = r_vsel == VS_C ? C :
              r_vsel == VS_PC ? WIDTH'(r_pc) :
              r_vsel == VS_IMM8 ? r_sximm8 : mdata;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      C <= '0;
      N <= 1'b0;
      V <= 1'b0;
      Z <= 1'b0;
    end else if (r_state == EXEC) begin
      C <= w_res;
      N <= w_res[WIDTH-1];
      V <= w_v;
      Z <= w_res == '0;
    end
  assign w_we = r_state == WB && r_wr_en;
  regfile_param #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_we),
    .i_waddr (r_wr_num),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed and random ops checked against an arithmetic model of the datapath
module tb_datapath_seq;
  localparam int W = 16;
  localparam int NR = 8;
  localparam int PW = 8;
  logic clk = 0, reset_n = 0, op_valid = 0, op_ready, wr_en = 0, asel = 0, bsel = 0, done;
  logic [2:0] rd_a = 0, rd_b = 0, wr_num = 0;
  logic [1:0] vsel = 0, shift = 0, alu_op = 0;
  logic [W-1:0] sximm5 = 0, sximm8 = 0, mdata = 0, C;
  logic [PW-1:0] pc = 0;
  logic N, V, Z;
  int tests = 0, fails = 0;
  int unsigned m_r [NR];

  always #5 clk = ~clk;

  datapath_seq #(.WIDTH(W), .NREGS(NR), .PCW(PW)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
    .rd_a(rd_a), .rd_b(rd_b), .wr_num(wr_num), .wr_en(wr_en), .vsel(vsel),
    .shift(shift), .alu_op(alu_op), .asel(asel), .bsel(bsel), .sximm5(sximm5),
    .sximm8(sximm8), .pc(pc), .mdata(mdata), .C(C), .N(N), .V(V), .Z(Z), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  function automatic int sgn(input int unsigned x);
    return x >= 32768 ? int'(x) - 65536 : int'(x);
  endfunction

  function automatic int unsigned sx(input int unsigned v, input int bits);
    return v >= (1 << (bits - 1)) ? v + 65536 - (1 << bits) : v;
  endfunction

  task automatic do_op(input string tag, input int ra, input int rb, input int wn, input bit we,
                       input int vs, input int sh, input int op, input bit as, input bit bs,
                       input int unsigned imm5, input int unsigned imm8, input int unsigned md,
                       input bit hold);
    int unsigned a, b, bv, res, wd;
    int sr;
    bit en, ev;
    a = as ? 0 : m_r[ra];
    bv = m_r[rb];
    b = bs ? imm5 : sh == 0 ? bv : sh == 1 ? (bv * 2) % 65536 : sh == 2 ? bv / 2 :
        bv / 2 + (bv >= 32768 ? 32768 : 0);
    ev = 0;
    if (op == 0) begin
      res = (a + b) % 65536;
      sr = sgn(a) + sgn(b);
      ev = sr > 32767 || sr < -32768;
    end else if (op == 1) begin
      res = (a + 65536 - b) % 65536;
      sr = sgn(a) - sgn(b);
      ev = sr > 32767 || sr < -32768;
    end else if (op == 2) res = a & b;
    else res = 65535 - b;
    en = res >= 32768;
    wd = vs == 0 ? res : vs == 1 ? int'(pc) : vs == 2 ? imm8 : md;
    chk({tag, "_ready_in"}, op_ready, 1);
    rd_a = 3'(ra); rd_b = 3'(rb); wr_num = 3'(wn); wr_en = we;
    vsel = 2'(vs); shift = 2'(sh); alu_op = 2'(op); asel = as; bsel = bs;
    sximm5 = 16'(imm5); sximm8 = 16'(imm8); mdata = 16'($urandom());
    op_valid = 1;
    edge1();
    op_valid = hold;
    rd_a = 3'($urandom()); rd_b = 3'($urandom()); wr_num = 3'($urandom()); wr_en = 1'($urandom());
    vsel = 2'($urandom()); shift = 2'($urandom()); alu_op = 2'($urandom());
    asel = 1'($urandom()); bsel = 1'($urandom()); sximm5 = 16'($urandom()); sximm8 = 16'($urandom());
    chk({tag, "_loada"}, {op_ready, done}, 2'b00);
    edge1();
    mdata = 16'(md);
    chk({tag, "_loadb"}, {op_ready, done}, 2'b00);
    edge1();
    chk({tag, "_exec"}, {op_ready, done}, 2'b00);
    edge1();
    chk({tag, "_wb"}, {op_ready, done}, 2'b01);
    edge1();
    chk({tag, "_idle"}, {op_ready, done}, 2'b10);
    chk({tag, "_c"}, C, res);
    chk({tag, "_nvz"}, {N, V, Z}, {en, ev, res == 0});
    if (we) m_r[wn] = wd;
  endtask

  task automatic readback(input string tag, input int r);
    do_op(tag, r, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (m_r[i]) m_r[i] = 0;
    #12;
    chk("reset_c", C, 0);
    chk("reset_nvzd", {N, V, Z, done, op_ready}, 5'b00001);
    @(posedge clk);
    #1 reset_n = 1;
    do_op("t1_w_r0", 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 7, 0, 0);
    readback("t1_rb_r0", 0);
    chk("t1_r0", C, 16'h0007);
    do_op("t2_w_r1", 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 16'h7FFF, 0);
    do_op("t2_w_r2", 0, 0, 2, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    do_op("t2_add", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_c_const", C, 16'h8000);
    chk("t2_nvz_const", {N, V, Z}, 3'b110);
    do_op("t3_w_r3", 0, 0, 3, 1, 2, 0, 0, 0, 0, 0, 5, 0, 0);
    do_op("t3_sub", 3, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("t3_sub_const", {C, N, V, Z}, {16'h0000, 3'b001});
    do_op("t3_w_r4", 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 0, 16'h8002, 0);
    do_op("t3_asr", 0, 4, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0);
    chk("t3_asr_const", {C, N}, {16'hC001, 1'b1});
    do_op("t4_r4", 1, 2, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_op("t4_r5", 4, 4, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    readback("t4_rb_r5", 5);
    chk("t4_r5_const", C, 16'h0000);
    readback("t4_rb_r4", 4);
    chk("t4_r4_const", C, 16'h8000);
    rd_a = 1; rd_b = 2; wr_num = 6; wr_en = 1; vsel = 2; shift = 0; alu_op = 0;
    asel = 0; bsel = 0; sximm8 = 16'h0055; op_valid = 1;
    edge1();
    op_valid = 0;
    edge1();
    edge1();
    reset_n = 0;
    #2;
    chk("t5_in_reset", {C, N, V, Z, done, op_ready}, {16'h0000, 5'b00001});
    edge1();
    reset_n = 1;
    foreach (m_r[i]) m_r[i] = 0;
    readback("t5_rb_r6", 6);
    chk("t5_r6_const", C, 16'h0000);
    pc = 8'hA5;
    do_op("t6_pc", 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    readback("t6_rb_pc", 7);
    chk("t6_pc_const", C, 16'h00A5);
    do_op("t6_md", 0, 0, 7, 1, 3, 0, 0, 0, 0, 0, 0, 16'h1234, 0);
    readback("t6_rb_md", 7);
    chk("t6_md_const", C, 16'h1234);
    for (int k = 0; k < 40; k++) begin
      pc = 8'($urandom());
      do_op($sformatf("rnd%0d", k), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 1'($urandom()), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, sx($urandom_range(0, 31), 5), sx($urandom_range(0, 255), 8),
            $urandom_range(0, 65535), 1'($urandom()));
    end
    op_valid = 0;
    for (int r = 0; r < NR; r++) readback($sformatf("final_r%0d", r), r);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
